// File: rtl/aes_pkg.sv
// Shared AES-128 constants, byte tables, GF(2^8) helpers and the decryptor FSM encoding.
// Byte 0 of every 128-bit block sits in bits [127:120].
package aes_pkg;

    localparam int NR = 10;

    // Index 0 of a [0:255] packed table is the most significant byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
    };

    // Entry 0 is unused padding so that RCON[i] pairs with round key i.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] key_expand_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word(rot_word(prev[31:0])) ^ {rc, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Start/done request bus of the AES-128 decryptor; the requester is master, the core is slave.
interface aes_decrypt_core_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] cipher_key;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (output start, ciphertext, cipher_key, input plaintext, done, busy);
    modport slave  (input start, ciphertext, cipher_key, output plaintext, done, busy);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last_round is set.
module aes_inv_round (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);
    import aes_pkg::*;

    logic [127:0] added;
    logic [127:0] mixed;

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

    // Row r of column c is taken from column (c - r) mod 4 of the input.
    // NOTE: every variable written here gets a default first so no path can infer a latch.
    always_comb begin
        added = '0;
        for (int k = 0; k < 16; k++) begin
            int src;
            src = 4 * (((k / 4) - (k % 4)) & 3) + (k % 4);
            added[8*(15-k) +: 8] = INV_SBOX[state_in[8*(15-src) +: 8]] ^ round_key[8*(15-k) +: 8];
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[32*(3-c) +: 32] = inv_mix_column(added[32*(3-c) +: 32]);
        end
    end

    assign state_out = last_round ? added : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: forward key expansion into a round-key file (optionally
// cached across jobs with the same key), then one inverse round per clock.
module aes_decrypt_core #(
    parameter int NR        = 10,
    parameter bit KEY_CACHE = 1'b1
) (
    input logic clk,
    input logic rst,
    aes_decrypt_core_if.slave bus
);
    import aes_pkg::*;

    if (NR != 10) begin : g_nr_check
        $error("aes_decrypt_core supports only NR = 10");
    end

    state_t       state, state_nx;
    logic         accept, cache_hit;
    logic [3:0]   kidx, r;
    logic [127:0] st, ct_q, pt_q, cached_key;
    logic         done_q, busy_q, cache_valid;
    logic [127:0] rk [0:10];
    logic [127:0] round_key, round_out;

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        cache_hit = KEY_CACHE && cache_valid && (bus.cipher_key == cached_key);
        case (state)
            IDLE, DONE: if (bus.start) begin
                accept   = 1'b1;
                state_nx = cache_hit ? INIT : KEXP;
            end
            KEXP:    if (kidx == 4'd10) state_nx = INIT;
            INIT:    state_nx = ROUND;
            ROUND:   if (r == 4'd1) state_nx = FINAL;
            FINAL:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kidx        <= 4'd0;
            r           <= 4'd0;
            st          <= '0;
            ct_q        <= '0;
            pt_q        <= '0;
            cached_key  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cache_valid <= 1'b0;
        end else begin
            if (accept) begin
                ct_q   <= bus.ciphertext;
                kidx   <= 4'd1;
                busy_q <= 1'b1;
                done_q <= 1'b0;
                // A miss is about to overwrite the key file, so the old cache entry dies now.
                if (!cache_hit) cache_valid <= 1'b0;
            end
            case (state)
                KEXP: begin
                    kidx <= kidx + 4'd1;
                    if (kidx == 4'd10) begin
                        cache_valid <= 1'b1;
                        cached_key  <= rk[0];
                    end
                end
                INIT: begin
                    st <= ct_q ^ rk[10];
                    r  <= 4'd9;
                end
                ROUND: begin
                    st <= round_out;
                    r  <= r - 4'd1;
                end
                FINAL: begin
                    pt_q   <= round_out;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the round-key file is plain storage without reset; cache_valid guards its contents.
    always_ff @(posedge clk) begin
        if (accept) rk[0] <= bus.cipher_key;
        if (state == KEXP) rk[kidx] <= key_expand_step(rk[kidx - 4'd1], RCON[kidx]);
    end

    assign round_key = (state == FINAL) ? rk[0] : rk[r];

    aes_inv_round u_inv_round (
        .state_in  (st),
        .round_key (round_key),
        .last_round(state == FINAL),
        .state_out (round_out)
    );

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule
